// File: rtl/sc1602_text_sequencer_if.sv
// Host/driver-facing signal bundle for sc1602_text_sequencer.
// master = host glue and driver side, slave = the sequencer.
interface sc1602_text_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW:0]   msg_len;
    logic          scroll_en;
    logic          scroll_dir;
    logic          drv_drawing;
    logic          drv_ready;
    logic [7:0]    character_out;
    logic [2:0]    command_out;
    logic [AW-1:0] char_index;
    logic          busy;
    logic          scroll_overrun;

    modport master (
        output wr_en, wr_addr, wr_data, msg_len,
        output scroll_en, scroll_dir, drv_drawing, drv_ready,
        input  character_out, command_out, char_index,
        input  busy, scroll_overrun
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, msg_len,
        input  scroll_en, scroll_dir, drv_drawing, drv_ready,
        output character_out, command_out, char_index,
        output busy, scroll_overrun
    );
endinterface

// File: rtl/sc1602_text_sequencer.sv
// Message buffer, character pointer and periodic scroll-command source
// feeding sc1602_driver.
module sc1602_text_sequencer #(
    parameter int         DEPTH         = 16,
    parameter int         SCROLL_PERIOD = 13_500_000,
    parameter logic [7:0] FILL_CHAR     = 8'h20
) (
    input logic sys_clk,
    input logic sys_rst_n,
    sc1602_text_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(SCROLL_PERIOD);
    localparam logic [PW-1:0] PMAX = PW'(SCROLL_PERIOD - 1);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RDY,
        ISSUE
    } state_e;

    logic [2:0]    draw_q;
    logic [1:0]    rdy_q;
    logic [7:0]    buf_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [7:0]    char_q;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    state_e        state_q;
    logic          dir_q;
    logic [2:0]    cmd_q;
    logic          ovr_q;

    logic          draw_fall;
    logic          ready_s;
    logic          tick;
    logic [AW:0]   len_eff;
    logic [AW:0]   ptr_inc;

    // draw_q[1:0] and rdy_q are plain 2-FF synchronisers; draw_q[2] is the edge history
    assign draw_fall = draw_q[2] & ~draw_q[1];
    assign ready_s   = rdy_q[1];
    assign tick      = (pcnt_q == PMAX);
    assign ptr_inc   = {1'b0, rd_ptr_q} + (AW + 1)'(1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            draw_q <= '0;
            rdy_q  <= '0;
        end else begin
            draw_q <= {draw_q[1:0], bus.drv_drawing};
            rdy_q  <= {rdy_q[0], bus.drv_ready};
        end
    end

    always_comb begin
        len_eff = bus.msg_len;
        if (bus.msg_len == '0 || bus.msg_len > DEPTH_L) begin
            len_eff = DEPTH_L;
        end
    end

    // A shrinking length is honoured in the same cycle as an advance
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (draw_fall) begin
            rd_ptr_d = (ptr_inc >= len_eff) ? '0 : ptr_inc[AW-1:0];
        end else if ({1'b0, rd_ptr_q} >= len_eff) begin
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= FILL_CHAR;
            end
        end else if (bus.wr_en) begin
            buf_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_ptr_q <= '0;
            char_q   <= FILL_CHAR;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            char_q   <= buf_q[rd_ptr_q];
        end
    end

    always_comb begin
        pcnt_d = pcnt_q + PW'(1);
        if (!bus.scroll_en || tick) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            cmd_q   <= 3'b000;
            ovr_q   <= 1'b0;
        end else begin
            if (tick && state_q != IDLE) begin
                ovr_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q <= WAIT_RDY;
                        dir_q   <= bus.scroll_dir;
                    end
                end
                WAIT_RDY: begin
                    if (!bus.scroll_en) begin
                        state_q <= IDLE;
                    end else if (ready_s) begin
                        cmd_q   <= {2'b01, dir_q};
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // ready dropping means the driver took the command
                    if (!ready_s) begin
                        cmd_q   <= 3'b000;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.character_out  = char_q;
    assign bus.command_out    = cmd_q;
    assign bus.char_index     = rd_ptr_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.scroll_overrun = ovr_q;
endmodule

// File: tb/tb_sc1602_text_sequencer.sv
// Directed plus randomized bench for sc1602_text_sequencer against
// a cycle-level reference model built from the behavioural rules.
module tb_sc1602_text_sequencer;
    localparam int DEPTH = 16;
    localparam int SP    = 8;
    localparam int AW    = $clog2(DEPTH);

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    sc1602_text_sequencer_if #(.DEPTH(DEPTH)) bus ();

    sc1602_text_sequencer #(
        .DEPTH(DEPTH),
        .SCROLL_PERIOD(SP),
        .FILL_CHAR(8'h20)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    int m_buf [DEPTH];
    int m_ptr, m_char, m_pcnt, m_st, m_dir, m_cmd, m_ovr;
    int dh [3];
    int rh [2];

    // Model: states 0 = idle, 1 = waiting for ready, 2 = command held
    always @(posedge sys_clk or negedge sys_rst_n) begin : model
        int len, fall, rdys, tk;
        if (!sys_rst_n) begin
            foreach (m_buf[i]) m_buf[i] = 32'h20;
            m_ptr = 0; m_char = 32'h20; m_pcnt = 0;
            m_st = 0; m_dir = 0; m_cmd = 0; m_ovr = 0;
            dh = '{0, 0, 0};
            rh = '{0, 0};
        end else begin
            len = int'(bus.msg_len);
            if (len == 0 || len > DEPTH) len = DEPTH;
            fall = (dh[2] == 1 && dh[1] == 0) ? 1 : 0;
            rdys = rh[1];
            tk = (m_pcnt == SP - 1) ? 1 : 0;
            m_char = m_buf[m_ptr];
            if (fall == 1) m_ptr = (m_ptr + 1 >= len) ? 0 : m_ptr + 1;
            else if (m_ptr >= len) m_ptr = 0;
            if (bus.wr_en) m_buf[bus.wr_addr] = int'(bus.wr_data);
            if (tk == 1 && m_st != 0) m_ovr = 1;
            case (m_st)
                0: if (tk == 1) begin m_st = 1; m_dir = int'(bus.scroll_dir); end
                1: begin
                    if (!bus.scroll_en) m_st = 0;
                    else if (rdys == 1) begin m_cmd = 2 + m_dir; m_st = 2; end
                end
                default: if (rdys == 0) begin m_cmd = 0; m_st = 0; end
            endcase
            if (!bus.scroll_en || tk == 1) m_pcnt = 0;
            else m_pcnt = m_pcnt + 1;
            dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = int'(bus.drv_drawing);
            rh[1] = rh[0]; rh[0] = int'(bus.drv_ready);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        chk("char_model", 32'(bus.character_out), m_char);
        chk("cmd_model", 32'(bus.command_out), m_cmd);
        chk("idx_model", 32'(bus.char_index), m_ptr);
        chk("busy_model", 32'(bus.busy), (m_st != 0) ? 1 : 0);
        chk("ovr_model", 32'(bus.scroll_overrun), m_ovr);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_char"}, 32'(bus.character_out), 32'h20);
        chk({tag, "_cmd"}, 32'(bus.command_out), 0);
        chk({tag, "_idx"}, 32'(bus.char_index), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_ovr"}, 32'(bus.scroll_overrun), 0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wr(input int a, input int d);
        bus.wr_en = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = 8'(d);
        cyc(1);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse();
        bus.drv_drawing = 1'b0;
        cyc(1);
        bus.drv_drawing = 1'b1;
        cyc(4);
    endtask

    logic [7:0] fpga [4];
    int n, cnt, prev;

    initial begin
        fpga = '{8'h46, 8'h50, 8'h47, 8'h41};
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.msg_len = '0; bus.scroll_en = 1'b0; bus.scroll_dir = 1'b0;
        bus.drv_drawing = 1'b1; bus.drv_ready = 1'b0;

        #2 sys_rst_n = 1'b0;
        #1 chk_reset("rst0");
        cyc(1);
        sys_rst_n = 1'b1;
        cyc(2);
        chk("post_rst_char", 32'(bus.character_out), 32'h20);
        cmp_all();

        // Wrap over a 4-character message
        for (int i = 0; i < 4; i++) wr(i, int'(fpga[i]));
        bus.msg_len = 5'd4;
        cyc(2);
        chk("wrap_init", 32'(bus.character_out), 32'(fpga[0]));
        for (int k = 0; k < 6; k++) begin
            bus.drv_drawing = 1'b0;
            cyc(3);
            chk("wrap_hold", 32'(bus.character_out), 32'(fpga[k % 4]));
            cyc(1);
            chk("wrap_new", 32'(bus.character_out), 32'(fpga[(k + 1) % 4]));
            cmp_all();
            bus.drv_drawing = 1'b1;
            cyc(3);
        end

        // Length shrink while the pointer is beyond the new end
        bus.msg_len = 5'd16;
        n = 0;
        while (bus.char_index != 4'd7 && n < 20) begin
            pulse();
            n++;
        end
        chk("shrink_pre", 32'(bus.char_index), 7);
        bus.msg_len = 5'd3;
        cyc(1);
        chk("shrink_idx", 32'(bus.char_index), 0);
        cyc(1);
        chk("shrink_char", 32'(bus.character_out), 32'(fpga[0]));
        cmp_all();

        // Scroll handshake, right direction
        bus.drv_ready = 1'b1;
        cyc(3);
        bus.scroll_dir = 1'b1;
        bus.scroll_en = 1'b1;
        n = 0;
        while (bus.command_out != 3'b011 && n < 40) begin
            cyc(1);
            n++;
        end
        chk("scroll_lat", n, SP + 1);
        chk("scroll_cmd", 32'(bus.command_out), 3);
        chk("scroll_busy", 32'(bus.busy), 1);
        bus.drv_ready = 1'b0;
        cyc(2);
        chk("scroll_hold", 32'(bus.command_out), 3);
        cyc(1);
        chk("scroll_clr", 32'(bus.command_out), 0);
        chk("scroll_idle", 32'(bus.busy), 0);
        chk("scroll_noovr", 32'(bus.scroll_overrun), 0);
        bus.scroll_en = 1'b0;
        cmp_all();

        // Overrun with the driver stalled
        cyc(3);
        bus.scroll_dir = 1'b0;
        bus.scroll_en = 1'b1;
        cyc(20);
        chk("ovr_busy", 32'(bus.busy), 1);
        chk("ovr_flag", 32'(bus.scroll_overrun), 1);
        cmp_all();
        bus.drv_ready = 1'b1;
        cnt = 0;
        prev = int'(bus.command_out);
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if (bus.command_out == 3'b010 && prev == 0) cnt++;
            prev = int'(bus.command_out);
            cmp_all();
        end
        chk("ovr_one_cmd", cnt, 1);
        chk("ovr_cmd_held", 32'(bus.command_out), 2);

        // Reset while the command is being held
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 chk_reset("rst_issue");
        cmp_all();
        bus.scroll_en = 1'b0;
        bus.drv_ready = 1'b0;
        cyc(1);
        sys_rst_n = 1'b1;
        cyc(1);

        // Randomized traffic against the model
        for (int c = 0; c < 900; c++) begin
            bus.wr_en = ($urandom_range(3) == 0);
            bus.wr_addr = AW'($urandom_range(DEPTH - 1));
            bus.wr_data = 8'($urandom_range(8'h7e, 8'h21));
            if ($urandom_range(39) == 0) bus.msg_len = 5'($urandom_range(31));
            if ($urandom_range(2) == 0) bus.drv_drawing = ~bus.drv_drawing;
            if ($urandom_range(5) == 0) bus.drv_ready = ~bus.drv_ready;
            if ($urandom_range(49) == 0) bus.scroll_en = ~bus.scroll_en;
            else if (c == 0) bus.scroll_en = 1'b1;
            bus.scroll_dir = 1'($urandom_range(1));
            if (c == 450) begin
                @(posedge sys_clk);
                #2 sys_rst_n = 1'b0;
                #1 chk_reset("rst_rand");
                @(negedge sys_clk);
                sys_rst_n = 1'b1;
            end
            cyc(1);
            cmp_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
